// File: rtl/conv3d_stage.sv
// 3x3xCH convolution stage: buffers a whole input tensor from BRAM, then walks
// every filter and output position with one serial multiply-accumulate.
module conv3d_stage #(
  parameter int DATA_W   = 17,
  parameter int IMG_H    = 8,
  parameter int IMG_W    = 8,
  parameter int CH       = 3,
  parameter int NUM_FILT = 4,
  parameter int ACC_W    = 35,
  localparam int N       = IMG_H * IMG_W * CH,
  localparam int IN_AW   = $clog2(N),
  localparam int W_AW    = $clog2(NUM_FILT * CH * 9),
  localparam int FILT_W  = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1,
  localparam int ROW_W   = (IMG_H > 3) ? $clog2(IMG_H - 2) : 1,
  localparam int COL_W   = (IMG_W > 3) ? $clog2(IMG_W - 2) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     relu_en,
  output logic                     busy,
  output logic                     done,
  output logic                     in_en,
  output logic [IN_AW-1:0]         in_addr,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     w_en,
  output logic [W_AW-1:0]          w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [FILT_W-1:0]        out_filt,
  output logic [ROW_W-1:0]         out_row,
  output logic [COL_W-1:0]         out_col
);

  localparam int TAPS  = CH * 9;
  localparam int MC_W  = $clog2(TAPS + 1);
  localparam int LD_W  = $clog2(N + 1);
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int MAC_W = 2 * DATA_W + 5;
  localparam int SAT_W = (MAC_W > ACC_W) ? MAC_W : ACC_W;

  localparam logic signed [SAT_W-1:0] SAT_MAX = {{(SAT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SAT_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, MAC, OUT, DONE} state_e;
  state_e state_q, state_d;

  logic [LD_W-1:0]          ld_cnt_q;
  logic                     ld_vld_q;
  logic [IN_AW-1:0]         ld_addr_q;
  logic [MC_W-1:0]          mac_cnt_q;
  logic [CH_W-1:0]          ch_q;
  logic [1:0]               kr_q, kc_q;
  logic                     mac_vld_q;
  logic [FILT_W-1:0]        f_q;
  logic [ROW_W-1:0]         row_q;
  logic [COL_W-1:0]         col_q;
  logic                     relu_q;
  logic signed [MAC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  res_q, res_d;
  logic signed [SAT_W-1:0]  acc_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] pix_q;
  logic signed [DATA_W-1:0] buf_mem [N];
  logic [IN_AW-1:0]         buf_raddr;
  logic                     load_last, mac_last, last_out;

  assign load_last = (ld_cnt_q == LD_W'(N));
  assign mac_last  = (mac_cnt_q == MC_W'(TAPS));
  assign last_out  = (f_q == FILT_W'(NUM_FILT - 1)) && (row_q == ROW_W'(IMG_H - 3)) &&
                     (col_q == COL_W'(IMG_W - 3));
  assign buf_raddr = IN_AW'(((int'(row_q) + int'(kr_q)) * IMG_W + int'(col_q) + int'(kc_q)) * CH
                            + int'(ch_q));

  // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    in_en     = 1'b0;
    in_addr   = '0;
    w_en      = 1'b0;
    w_addr    = '0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        busy = 1'b1;
        if (!load_last) begin
          in_en   = 1'b1;
          in_addr = ld_cnt_q[IN_AW-1:0];
        end else begin
          state_d = MAC;
        end
      end
      MAC: begin
        busy = 1'b1;
        if (!mac_last) begin
          w_en   = 1'b1;
          w_addr = W_AW'(int'(f_q) * TAPS + int'(mac_cnt_q));
        end else begin
          state_d = OUT;
        end
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = last_out ? DONE : MAC;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Products are exact and the accumulator has headroom for every tap; clamp only at the end.
  assign prod = pix_q * w_data;

  always_comb begin
    acc_d = acc_q;
    if (mac_vld_q) acc_d = acc_q + MAC_W'(prod);
    acc_x = SAT_W'(acc_d);
    if (acc_x > SAT_MAX)      res_d = ACC_MAX;
    else if (acc_x < SAT_MIN) res_d = ACC_MIN;
    else                      res_d = acc_x[ACC_W-1:0];
    if (relu_q && res_d[ACC_W-1]) res_d = '0;
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ld_cnt_q  <= '0;
      ld_vld_q  <= 1'b0;
      ld_addr_q <= '0;
      mac_cnt_q <= '0;
      ch_q      <= '0;
      kr_q      <= '0;
      kc_q      <= '0;
      mac_vld_q <= 1'b0;
      f_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      relu_q    <= 1'b0;
      acc_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      ld_vld_q  <= in_en;
      ld_addr_q <= in_addr;
      mac_vld_q <= w_en;
      if (state_q == IDLE && start) relu_q <= relu_en;
      if (state_q == LOAD) ld_cnt_q <= load_last ? '0 : ld_cnt_q + LD_W'(1);
      if (state_q == MAC) begin
        acc_q     <= acc_d;
        mac_cnt_q <= mac_last ? '0 : mac_cnt_q + MC_W'(1);
        if (mac_last) res_q <= res_d;
      end
      if (state_d == MAC && state_q != MAC) acc_q <= '0;
      if (w_en) begin
        if (kc_q == 2'd2) begin
          kc_q <= 2'd0;
          if (kr_q == 2'd2) begin
            kr_q <= 2'd0;
            ch_q <= (ch_q == CH_W'(CH - 1)) ? '0 : ch_q + CH_W'(1);
          end else begin
            kr_q <= kr_q + 2'd1;
          end
        end else begin
          kc_q <= kc_q + 2'd1;
        end
      end
      if (state_q == OUT && out_ready && !last_out) begin
        if (col_q == COL_W'(IMG_W - 3)) begin
          col_q <= '0;
          if (row_q == ROW_W'(IMG_H - 3)) begin
            row_q <= '0;
            f_q   <= f_q + FILT_W'(1);
          end else begin
            row_q <= row_q + ROW_W'(1);
          end
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      if (state_q == DONE) begin
        f_q   <= '0;
        row_q <= '0;
        col_q <= '0;
      end
    end
  end

  // NOTE: the tensor buffer has no reset; each run rewrites all N entries before any read.
  always_ff @(posedge clk) begin
    if (ld_vld_q) buf_mem[ld_addr_q] <= in_data;
    if (w_en)     pix_q <= buf_mem[buf_raddr];
  end

  assign out_data = res_q;
  assign out_filt = f_q;
  assign out_row  = row_q;
  assign out_col  = col_q;

endmodule

// File: tb/tb_conv3d_stage.sv
// Bench for conv3d_stage: directed and random tensors against an arithmetic
// reference, plus a cycle-level timing model for runs with out_ready held high.
module tb_conv3d_stage;
  localparam int DATA_W = 17, IMG_H = 8, IMG_W = 8, CH = 3, NUM_FILT = 4, ACC_W = 35;
  localparam int N = IMG_H * IMG_W * CH;
  localparam int NW = NUM_FILT * CH * 9;
  localparam int OH = IMG_H - 2, OW = IMG_W - 2;
  localparam int NOUT = NUM_FILT * OH * OW;
  localparam int RUN_CYC = N + 1 + 29 * NOUT + 1;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, relu_en = 1'b0, out_ready = 1'b1;
  logic signed [DATA_W-1:0] in_data = '0, w_data = '0;
  logic busy, done, in_en, w_en, out_valid;
  logic [7:0] in_addr;
  logic [6:0] w_addr;
  logic signed [ACC_W-1:0] out_data;
  logic [1:0] out_filt;
  logic [2:0] out_row, out_col;
  logic busy18, done18, in_en18, w_en18, out_valid18;
  logic [7:0] in_addr18;
  logic [6:0] w_addr18;
  logic signed [17:0] out_data18;
  logic [1:0] out_filt18;
  logic [2:0] out_row18, out_col18;

  int img [N];
  int wts [NW];
  int total = 0, passed = 0, failed = 0;

  conv3d_stage dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .busy(busy), .done(done),
    .in_en(in_en), .in_addr(in_addr), .in_data(in_data), .w_en(w_en), .w_addr(w_addr),
    .w_data(w_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_filt(out_filt), .out_row(out_row), .out_col(out_col)
  );

  conv3d_stage #(.ACC_W(18)) dut18 (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .busy(busy18), .done(done18),
    .in_en(in_en18), .in_addr(in_addr18), .in_data(in_data), .w_en(w_en18), .w_addr(w_addr18),
    .w_data(w_data), .out_valid(out_valid18), .out_ready(out_ready), .out_data(out_data18),
    .out_filt(out_filt18), .out_row(out_row18), .out_col(out_col18)
  );

  always #5 clk = ~clk;

  // Memories with one-cycle read latency; both instances run in lockstep on shared data.
  always @(posedge clk) begin
    if (in_en) in_data <= DATA_W'(img[in_addr]);
    if (w_en)  w_data  <= DATA_W'(wts[w_addr]);
  end

  task automatic check(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint conv_ref(int f, int r, int c, int accw, bit relu);
    longint s = 0, mx, mn;
    for (int ch = 0; ch < CH; ch++)
      for (int kr = 0; kr < 3; kr++)
        for (int kc = 0; kc < 3; kc++)
          s += longint'(img[((r + kr) * IMG_W + c + kc) * CH + ch]) *
               longint'(wts[((f * CH + ch) * 3 + kr) * 3 + kc]);
    mx = (longint'(1) <<< (accw - 1)) - 1;
    mn = -mx - 1;
    if (s > mx) s = mx;
    if (s < mn) s = mn;
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  // Expected {busy,done,in_en,w_en,out_valid,in_addr,w_addr} for busy cycle cyc, out_ready high.
  function automatic longint exp_ctrl(int cyc);
    logic b = 1'b0, d = 1'b0, ie = 1'b0, we = 1'b0, ov = 1'b0;
    logic [7:0] ia = '0;
    logic [6:0] wa = '0;
    int k, m;
    if (cyc >= 1 && cyc <= RUN_CYC) b = 1'b1;
    if (cyc == RUN_CYC) d = 1'b1;
    if (cyc >= 1 && cyc <= N) begin
      ie = 1'b1;
      ia = 8'(cyc - 1);
    end
    if (cyc >= N + 2 && cyc < RUN_CYC) begin
      k = cyc - (N + 2);
      m = k % 29;
      if (m < 27) begin
        we = 1'b1;
        wa = 7'(((k / 29) / (OH * OW)) * 27 + m);
      end
      if (m == 28) ov = 1'b1;
    end
    return longint'({b, d, ie, we, ov, ia, wa});
  endfunction

  task automatic fill(input int iv, input int wv);
    for (int a = 0; a < N; a++) img[a] = iv;
    for (int a = 0; a < NW; a++) wts[a] = wv;
  endtask

  task automatic run(input bit relu, input bit stall);
    int idx = 0, cyc = 0, stall_left, f, r, c;
    bit fin = 1'b0;
    longint e, e18;
    stall_left = stall ? 10 : 0;
    relu_en = relu;
    start = 1'b1;
    while (!fin && cyc < RUN_CYC + 100) begin
      @(negedge clk);
      cyc++;
      start = stall && cyc >= 300 && cyc < 305;
      if (cyc == 1) relu_en = !relu;
      if (!stall) begin
        check("ctrl", longint'({busy, done, in_en, w_en, out_valid, in_addr, w_addr}), exp_ctrl(cyc));
        check("ctrl18", longint'({busy18, done18, in_en18, w_en18, out_valid18, in_addr18, w_addr18}),
              exp_ctrl(cyc));
      end else begin
        check("en_excl", longint'(in_en & w_en), 0);
      end
      out_ready = 1'b1;
      if (out_valid) begin
        f = idx / (OH * OW);
        r = (idx / OW) % OH;
        c = idx % OW;
        e = conv_ref(f, r, c, ACC_W, relu);
        e18 = conv_ref(f, r, c, 18, relu);
        if (stall && idx == 2 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end
        check("data", longint'(out_data), e);
        check("index", longint'({out_filt, out_row, out_col}), longint'(f * 64 + r * 8 + c));
        check("data18", longint'(out_data18), e18);
        check("index18", longint'({out_filt18, out_row18, out_col18}), longint'(f * 64 + r * 8 + c));
        if (out_ready) idx++;
      end
      if (done) begin
        fin = 1'b1;
        check("n_results", idx, NOUT);
        if (!stall) check("done_cycle", cyc, RUN_CYC);
      end
    end
    check("done_seen", longint'(fin), 1);
    start = 1'b0;
    @(negedge clk);
    check("idle_after", longint'({busy, done, out_valid, busy18}), 0);
  endtask

  initial begin
    logic signed [DATA_W-1:0] v;
    int cyc;
    // Power-on reset state
    @(negedge clk);
    check("rst_ctrl", longint'({busy, done, in_en, w_en, out_valid, in_addr, w_addr}), 0);
    check("rst_data", longint'({out_data, out_filt, out_row, out_col}), 0);
    reset = 1'b1;
    @(negedge clk);

    // All-ones tensor and weights
    fill(1, 1);
    run(1'b0, 1'b0);

    // Ramp input, single centre tap of ch0 per filter
    for (int a = 0; a < N; a++) img[a] = a;
    for (int a = 0; a < NW; a++) wts[a] = 0;
    for (int f = 0; f < NUM_FILT; f++) wts[f * 27 + 4] = f + 1;
    run(1'b0, 1'b0);

    // Negative sums with and without ReLU
    fill(1, -1);
    run(1'b1, 1'b0);
    run(1'b0, 1'b0);

    // Saturation at both ends (ACC_W=35 and ACC_W=18 instances)
    fill(65535, 65535);
    run(1'b0, 1'b0);
    fill(-65536, 65535);
    run(1'b0, 1'b0);

    // Random full-range data, output stall and ignored start pulses
    for (int a = 0; a < N; a++) begin
      v = DATA_W'($urandom);
      img[a] = int'(v);
    end
    for (int a = 0; a < NW; a++) begin
      v = DATA_W'($urandom);
      wts[a] = int'(v);
    end
    run(1'($urandom_range(0, 1)), 1'b1);

    // Reset during the 5th MAC cycle, then a clean rerun
    fill(1, 1);
    relu_en = 1'b0;
    start = 1'b1;
    cyc = 0;
    while (cyc < N + 6) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    check("pre_reset", longint'({busy, done, in_en, w_en, out_valid, in_addr, w_addr}), exp_ctrl(cyc));
    reset = 1'b0;
    #1;
    check("mid_rst_ctrl", longint'({busy, done, in_en, w_en, out_valid, in_addr, w_addr}), 0);
    check("mid_rst_data", longint'({out_data, out_filt, out_row, out_col}), 0);
    check("mid_rst_ctrl18", longint'({busy18, done18, in_en18, w_en18, out_valid18, in_addr18, w_addr18}), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/conv3d_stage.md
CONV3D_STAGE -- requirements
Module: conv3d_stage

Interface
REQ-001 Parameter DATA_W, 17, signed width of input and weight samples.
REQ-002 Parameter IMG_H, 8, input tensor rows; legal range >= 3.
REQ-003 Parameter IMG_W, 8, input tensor columns; legal range >= 3.
REQ-004 Parameter CH, 3, input channels; legal range >= 1.
REQ-005 Parameter NUM_FILT, 4, number of 3x3xCH filters; legal range >= 1.
REQ-006 Parameter ACC_W, 35, signed output width; legal range DATA_W+1 .. 2*DATA_W+8.
REQ-007 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 reset  input  1  asynchronous active-low reset.
REQ-010 start  input  1  request for one stage run; sampled only in IDLE.
REQ-011 relu_en  input  1  ReLU mode; captured on an accepted start.
REQ-012 busy  output  1  high from the cycle after an accepted start until the done cycle, inclusive.
REQ-013 done  output  1  single-cycle pulse after the last output handshake.
REQ-014 in_en  output  1  input BRAM read enable.
REQ-015 in_addr  output  clog2(IMG_H*IMG_W*CH)  input address = (r*IMG_W + c)*CH + ch.
REQ-016 in_data  input  DATA_W  signed input sample, valid 1 cycle after in_en.
REQ-017 w_en  output  1  weight ROM read enable.
REQ-018 w_addr  output  clog2(NUM_FILT*CH*9)  weight address = ((f*CH + ch)*3 + kr)*3 + kc.
REQ-019 w_data  input  DATA_W  signed weight, valid 1 cycle after w_en.
REQ-020 out_valid  output  1  result available.
REQ-021 out_ready  input  1  consumer accepts the result when high together with out_valid.
REQ-022 out_data  output  ACC_W  signed result.
REQ-023 out_filt / out_row / out_col  output  clog2 widths  filter index and output coordinate of out_data.

Function
REQ-024 FSM states SHALL be IDLE, LOAD, MAC, OUT, DONE.
REQ-025 IDLE->LOAD on start=1; start SHALL be ignored in every other state.
REQ-026 LOAD SHALL last N+1 cycles (N = IMG_H*IMG_W*CH): in_en high for the first N cycles at in_addr 0..N-1 in ascending order; each returned sample is stored in an internal IMG_H x IMG_W x CH buffer.
REQ-027 Outputs SHALL be produced filter-major, then out_row 0..IMG_H-3, then out_col 0..IMG_W-3; NUM_FILT*(IMG_H-2)*(IMG_W-2) results per run.
REQ-028 Each MAC visit SHALL last 28 cycles: accumulator cleared on entry; w_en high for cycles 1..27, taps in ch, kr, kc order (kc fastest); product with buffer[row+kr][col+kc][ch] accumulated in cycles 2..28.
REQ-029 Accumulator SHALL be signed 2*DATA_W+5 bits; products SHALL be exact and the accumulator SHALL never wrap.
REQ-030 On MAC exit the result SHALL be saturated to signed ACC_W (clamped to max/min), then forced to 0 if negative and relu_en was captured high.
REQ-031 OUT SHALL hold out_valid=1 with out_data/out_filt/out_row/out_col stable until out_ready=1; on handshake go to MAC for the next output, or DONE after the last.
REQ-032 DONE SHALL last one cycle with done=1, then return to IDLE; busy falls the following cycle.
REQ-033 in_en and w_en SHALL never be high outside LOAD and MAC respectively.
REQ-034 With out_ready tied high, a run SHALL take exactly N+1 + 29*NUM_FILT*(IMG_H-2)*(IMG_W-2) + 1 cycles from the first busy cycle to done.

Reset
REQ-035 reset=0 SHALL immediately force IDLE, clear the accumulator and counters, and drive busy, done, in_en, w_en, out_valid to 0 and all address/data/index outputs to 0, including mid-LOAD, mid-MAC or mid-OUT.
REQ-036 Internal buffer contents need not be cleared; a new start after reset SHALL reload them fully.

Verification
REQ-037 Defaults, all in_data=1, all w_data=1, out_ready=1 -> 144 results each 27, first out_filt=0/row=0/col=0, done at cycle 1+192+1+144*29 after start.
REQ-038 in_data = in_addr, weights of filter f = f+1 at centre tap of ch0 only -> out_data = (f+1)*(((row+1)*8+col+1)*3) for every output.
REQ-039 All weights -1, inputs 1, relu_en=1 -> every result 0; relu_en=0 -> every result -27.
REQ-040 ACC_W=18, inputs and weights 65535 -> every result saturates to 131071; inputs -65536, weights 65535 -> -131072.
REQ-041 out_ready low 10 cycles at the third output -> out_valid and outputs stable throughout; no result lost or duplicated; start pulses during run ignored.
REQ-042 reset asserted in the 5th MAC cycle -> all outputs 0 same cycle; new start yields results identical to REQ-037.
